// File: rtl/pulse_period_monitor.sv
`default_nettype none
// ============================================================================
// pulse_period_monitor : measures the gap between rising pulse events, flags
// early/late pulses, tracks lock. Optional macro: PERIOD_MON_STATS_EN.
// Revision: 1.0
// ============================================================================
module pulse_period_monitor #(
   parameter int CNT_W   = 16,
   parameter int MIN_GAP = 2,
   parameter int MAX_GAP = 1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pulse_in,
   output logic [CNT_W-1:0] period_data,
   output logic             period_valid,
   input  logic             period_ready,
   output logic             early_err,
   output logic             timeout,
   output logic             overrun,
   output logic             locked
`ifdef PERIOD_MON_STATS_EN
   ,
   output logic [CNT_W-1:0] event_count
`endif
);

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_min_gap = CNT_W'(MIN_GAP);
   localparam logic [CNT_W-1:0] c_max_gap = CNT_W'(MAX_GAP);

   state_t           state_q, state_d;
   logic             pulse_in_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             early_q, early_d;
   logic             timeout_q, timeout_d;
   logic             overrun_q, overrun_d;
   logic             locked_q, locked_d;
   logic [CNT_W-1:0] prev_q, prev_d;
   logic             have_prev_q, have_prev_d;
   logic             w_event;
   logic             w_capture;

   assign w_event = pulse_in & ~pulse_in_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      early_d     = 1'b0;
      timeout_d   = 1'b0;
      locked_d    = locked_q;
      prev_d      = prev_q;
      have_prev_d = have_prev_q;
      w_capture   = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (w_event) begin
               state_d = MEASURE;
               cnt_d   = c_one;
            end
         end
         MEASURE: begin
            // An event on the MAX_GAP cycle is a legal period, so it is tested first.
            if (w_event) begin
               cnt_d = c_one;
               if (cnt_q < c_min_gap) begin
                  early_d     = 1'b1;
                  locked_d    = 1'b0;
                  have_prev_d = 1'b0;
               end else begin
                  w_capture   = 1'b1;
                  locked_d    = have_prev_q && (cnt_q == prev_q);
                  prev_d      = cnt_q;
                  have_prev_d = 1'b1;
               end
            end else if (cnt_q == c_max_gap) begin
               timeout_d   = 1'b1;
               state_d     = IDLE;
               cnt_d       = '0;
               locked_d    = 1'b0;
               have_prev_d = 1'b0;
            end else begin
               cnt_d = cnt_q + c_one;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      data_d    = data_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      if (valid_q && period_ready) begin
         valid_d = 1'b0;
      end
      // A handshake completing this cycle frees the slot for the new period.
      if (w_capture) begin
         if (!valid_q || period_ready) begin
            data_d  = cnt_q;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         pulse_in_q  <= 1'b0;
         cnt_q       <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         early_q     <= 1'b0;
         timeout_q   <= 1'b0;
         overrun_q   <= 1'b0;
         locked_q    <= 1'b0;
         prev_q      <= '0;
         have_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pulse_in_q  <= pulse_in;
         cnt_q       <= cnt_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         early_q     <= early_d;
         timeout_q   <= timeout_d;
         overrun_q   <= overrun_d;
         locked_q    <= locked_d;
         prev_q      <= prev_d;
         have_prev_q <= have_prev_d;
      end
   end

   assign period_data  = data_q;
   assign period_valid = valid_q;
   assign early_err    = early_q;
   assign timeout      = timeout_q;
   assign overrun      = overrun_q;
   assign locked       = locked_q;

`ifdef PERIOD_MON_STATS_EN
   logic [CNT_W-1:0] ev_count_q, ev_count_d;

   always_comb begin
      ev_count_d = ev_count_q;
      if (w_capture && (ev_count_q != '1)) begin
         ev_count_d = ev_count_q + c_one;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ev_count_q <= '0;
      end else begin
         ev_count_q <= ev_count_d;
      end
   end

   assign event_count = ev_count_q;
`endif

endmodule
`default_nettype wire
